// File: rtl/gates_mux_2by1_vec_checker.sv
// gates_mux_2by1_vec_checker: sweeps {a,b} through 00..11 into a gate block and checks its seven outputs
module gates_mux_2by1_vec_checker #(
  parameter int HOLD_CYCLES = 4,
  parameter int ERR_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a,
  output logic             b,
  input  logic             c_and,
  input  logic             c_or,
  input  logic             c_not,
  input  logic             c_xor,
  input  logic             c_xnor,
  input  logic             c_nand,
  input  logic             c_nor,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       err_vec,
  output logic [6:0]       fail_gates
);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;
  state_t state, state_nx;
  logic [HW-1:0] hold, hold_nx;
  logic [1:0] vec, vec_nx;
  logic [ERR_W-1:0] err_nx;
  logic [3:0] ev_nx;
  logic [6:0] fg_nx, golden, mism;
  assign busy = state == DRIVE || state == CHECK;
  assign done = state == DONE;
  assign pass = done && err_vec == 4'd0;
  assign a = busy & vec[1];
  assign b = busy & vec[0];
  // golden bit order matches fail_gates: {nor,nand,xnor,xor,not,or,and}
  assign golden = {~(vec[1] | vec[0]), ~(vec[1] & vec[0]), ~(vec[1] ^ vec[0]),
                   vec[1] ^ vec[0], ~vec[1], vec[1] | vec[0], vec[1] & vec[0]};
  assign mism = {c_nor, c_nand, c_xnor, c_xor, c_not, c_or, c_and} ^ golden;
  always_comb begin
    state_nx = state;
    hold_nx = hold;
    vec_nx = vec;
    err_nx = err_count;
    ev_nx = err_vec;
    fg_nx = fail_gates;
    case (state)
      IDLE, DONE: if (start) begin
        state_nx = DRIVE;
        hold_nx = '0;
        vec_nx = 2'd0;
        err_nx = '0;
        ev_nx = 4'd0;
        fg_nx = 7'd0;
      end
      DRIVE: begin
        hold_nx = hold + 1'b1;
        state_nx = hold == HW'(HOLD_CYCLES - 1) ? CHECK : DRIVE;
      end
      CHECK: begin
        if (|mism) begin
          ev_nx[vec] = 1'b1;
          fg_nx = fail_gates | mism;
          err_nx = &err_count ? err_count : err_count + 1'b1;
        end
        state_nx = vec == 2'd3 ? DONE : DRIVE;
        vec_nx = vec == 2'd3 ? vec : vec + 2'd1;
        hold_nx = '0;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      hold <= '0;
      vec <= 2'd0;
      err_count <= '0;
      err_vec <= 4'd0;
      fail_gates <= 7'd0;
    end else begin
      state <= state_nx;
      hold <= hold_nx;
      vec <= vec_nx;
      err_count <= err_nx;
      err_vec <= ev_nx;
      fail_gates <= fg_nx;
    end
  end
endmodule

// File: tb/tb_gates_mux_2by1_vec_checker.sv
// tb_gates_mux_2by1_vec_checker: two checker instances (HOLD 4/ERR_W 3 and HOLD 1/ERR_W 1) against a sweep-level model
module tb_gates_mux_2by1_vec_checker;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, en = 1'b0;
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  int hcyc[2] = '{4, 1};
  int ew[2] = '{3, 1};
  int fault[2] = '{0, 0};
  int mf[2] = '{0, 0};
  int ph[2] = '{0, 0};
  int t[2] = '{0, 0};
  logic a0, b0, busy0, done0, pass0, a1, b1, busy1, done1, pass1;
  logic [2:0] cnt0;
  logic [0:0] cnt1;
  logic [3:0] ev0, ev1;
  logic [6:0] fg0, fg1, c0, c1;
  typedef struct packed {
    logic a, b, busy, done, pass;
    logic [7:0] cnt;
    logic [3:0] ev;
    logic [6:0] fg;
  } obs_t;
  // gate block stand-in: f=0 ideal, f=1 xor stuck at 0, f=2 every output inverted
  function automatic logic [6:0] gates(logic x, logic y, int f);
    logic [6:0] g;
    g = {~(x | y), ~(x & y), ~(x ^ y), x ^ y, ~x, x | y, x & y};
    if (f == 1) g[3] = 1'b0;
    if (f == 2) g = ~g;
    return g;
  endfunction
  assign c0 = gates(a0, b0, fault[0]);
  assign c1 = gates(a1, b1, fault[1]);
  gates_mux_2by1_vec_checker #(.HOLD_CYCLES(4), .ERR_W(3)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a0), .b(b0),
    .c_and(c0[0]), .c_or(c0[1]), .c_not(c0[2]), .c_xor(c0[3]), .c_xnor(c0[4]), .c_nand(c0[5]), .c_nor(c0[6]),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(cnt0), .err_vec(ev0), .fail_gates(fg0));
  gates_mux_2by1_vec_checker #(.HOLD_CYCLES(1), .ERR_W(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a1), .b(b1),
    .c_and(c1[0]), .c_or(c1[1]), .c_not(c1[2]), .c_xor(c1[3]), .c_xnor(c1[4]), .c_nand(c1[5]), .c_nor(c1[6]),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(cnt1), .err_vec(ev1), .fail_gates(fg1));
  // ph: 0 idle, 1 sweeping (t = cycles since start accepted), 2 done
  always @(posedge clk)
    for (int i = 0; i < 2; i++)
      if (!rst_n) begin
        ph[i] = 0;
        t[i] = 0;
      end else if (ph[i] != 1 && start) begin
        ph[i] = 1;
        t[i] = 0;
        mf[i] = fault[i];
      end else if (ph[i] == 1) begin
        t[i]++;
        if (t[i] == 4 * (hcyc[i] + 1)) ph[i] = 2;
      end
  function automatic obs_t model(int i);
    obs_t o;
    int n;
    logic [6:0] m;
    logic [1:0] kv;
    o = '0;
    n = ph[i] == 1 ? t[i] / (hcyc[i] + 1) : ph[i] == 2 ? 4 : 0;
    if (ph[i] == 1) begin
      kv = 2'(n);
      o.busy = 1'b1;
      o.a = kv[1];
      o.b = kv[0];
    end
    for (int k = 0; k < n; k++) begin
      kv = 2'(k);
      m = gates(kv[1], kv[0], mf[i]) ^ gates(kv[1], kv[0], 0);
      if (m != 7'd0) begin
        o.ev[k] = 1'b1;
        o.fg = o.fg | m;
        if (int'(o.cnt) < (1 << ew[i]) - 1) o.cnt = o.cnt + 8'd1;
      end
    end
    o.done = ph[i] == 2;
    o.pass = ph[i] == 2 && o.ev == 4'd0;
    return o;
  endfunction
  always @(negedge clk)
    if (en) begin
      obs_t g0, g1, e0, e1;
      g0 = {a0, b0, busy0, done0, pass0, 8'(cnt0), ev0, fg0};
      g1 = {a1, b1, busy1, done1, pass1, 8'(cnt1), ev1, fg1};
      e0 = model(0);
      e1 = model(1);
      checks += 2;
      if (g0 != e0) begin
        failures++;
        $display("FAIL u0_cycle t=%0d got=%h exp=%h", t[0], g0, e0);
      end
      if (g1 != e1) begin
        failures++;
        $display("FAIL u1_cycle t=%0d got=%h exp=%h", t[1], g1, e1);
      end
    end
  task automatic chk(string nm, int got, int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask
  task automatic pulse_start;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask
  task automatic sweep(input int mid, output int nb, output int fd0, output int fd1, output logic [15:0] seq);
    nb = 0;
    fd0 = -1;
    fd1 = -1;
    seq = '0;
    pulse_start();
    for (int i = 0; i < 30; i++) begin
      start = i == mid;
      if (busy0) nb++;
      if (done0 && fd0 < 0) fd0 = i;
      if (done1 && fd1 < 0) fd1 = i;
      if (i < 8) seq = {seq[13:0], a1, b1};
      @(negedge clk);
    end
    start = 1'b0;
  endtask
  initial begin
    int nb, fd0, fd1, nd;
    logic [15:0] seq;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1;
    chk("rst_busy", busy0, 0);
    chk("rst_done_pass", {done0, pass0}, 0);
    chk("rst_results", {cnt0, ev0, fg0}, 0);
    sweep(-1, nb, fd0, fd1, seq);
    chk("ideal_busy_cycles", nb, 20);
    chk("ideal_done_at", fd0, 20);
    chk("ideal_result", {pass0, cnt0, ev0, fg0}, 15'h4000);
    chk("hold1_ab_seq", seq, 16'h05AF);
    chk("hold1_done_at", fd1, 8);
    fault[0] = 1;
    fault[1] = 2;
    sweep(-1, nb, fd0, fd1, seq);
    chk("xor_stuck_err_vec", ev0, 4'b0110);
    chk("xor_stuck_fail_gates", fg0, 7'b0001000);
    chk("xor_stuck_cnt_pass", {cnt0, pass0}, 4'b0100);
    chk("inv_err_vec", ev1, 4'hF);
    chk("inv_fail_gates", fg1, 7'h7F);
    chk("inv_cnt_sat_pass", {cnt1, pass1}, 2'b10);
    fault[0] = 0;
    fault[1] = 0;
    pulse_start();
    chk("restart_cleared", {cnt0, ev0, fg0, busy0}, 1);
    repeat (30) @(negedge clk);
    sweep(5, nb, fd0, fd1, seq);
    chk("midstart_busy_cycles", nb, 20);
    chk("midstart_done_at", fd0, 20);
    chk("midstart_pass", pass0, 1);
    pulse_start();
    repeat (11) @(negedge clk);
    chk("vec2_drive_ab", {busy0, a0, b0}, 3'b110);
    rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    chk("abort_outputs", {a0, b0, busy0, done0, pass0, cnt0, ev0, fg0}, 0);
    nd = 0;
    for (int i = 0; i < 30; i++) begin
      if (done0) nd++;
      @(negedge clk);
    end
    chk("abort_no_done", nd, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
